i2s_tx: RTL and testbench



---
 rtl/i2s_pkg.sv | 11 +
 rtl/i2s_clkgen.sv | 31 +++
 rtl/i2s_tx.sv | 79 +++++++
 tb/tb_i2s_tx.sv | 132 +++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: frame constants and slot bit mapping shared by the I2S transmitter
package i2s_pkg;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS = 32;
  // Data index inside a slot for frame bit b (MSB at slot bit 1), -1 for padding.
  function automatic int bit_index(input int b, input int dw);
    int s;
    s = b % SLOT_BITS;
    return (s >= 1 && s <= dw) ? dw - s : -1;
  endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: free-running phase counter producing mclk, sclk and the sclk-fall strobe
// clk, reset : system clock, async active-high reset
// mclk, sclk : registered master and bit clocks
// fall_evt   : high in the cycle whose rising clk edge drives sclk low
module i2s_clkgen #(
  parameter int MCLK_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  output logic mclk,
  output logic sclk,
  output logic fall_evt
);
  localparam int PER = 8 * MCLK_HALF;
  localparam int PW = $clog2(PER);
  logic [PW-1:0] ph, ph_next;
  always_comb begin
    fall_evt = int'(ph) == PER - 1;
    ph_next = fall_evt ? '0 : ph + PW'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ph <= '0;
      mclk <= 1'b0;
      sclk <= 1'b0;
    end else begin
      ph <= ph_next;
      mclk <= int'(ph_next) % (2 * MCLK_HALF) >= MCLK_HALF;
      sclk <= int'(ph_next) >= 4 * MCLK_HALF;
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S stereo transmitter with one-deep holding register
// clk, reset           : system clock, async active-high reset
// pcm_l, pcm_r         : signed samples, taken when in_valid && in_ready
// in_valid, in_ready   : input handshake; in_ready means holding register empty
// mclk, sclk, lrck     : DAC clocks (lrck 0 = left)
// sdata                : serial data, MSB first, one sclk after the lrck edge
// frame_tick, underrun : one-clk pulses at frame start / frame without new sample
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int MCLK_HALF = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pcm_l,
  input  logic [DW-1:0] pcm_r,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mclk,
  output logic          sclk,
  output logic          lrck,
  output logic          sdata,
  output logic          frame_tick,
  output logic          underrun
);
  localparam int BW = $clog2(FRAME_BITS);
  logic fall_evt, hold_full, load, sbit;
  logic [DW-1:0] hold_l, hold_r, sh_l, sh_r, word;
  logic [BW-1:0] bit_cnt, b;
  int idx;
  i2s_clkgen #(.MCLK_HALF(MCLK_HALF)) u_clkgen (
    .clk(clk),
    .reset(reset),
    .mclk(mclk),
    .sclk(sclk),
    .fall_evt(fall_evt)
  );
  assign in_ready = ~hold_full;
  // Everything below is evaluated for the bit that starts on the coming fall event.
  always_comb begin
    b = bit_cnt + BW'(1);
    load = fall_evt && b == '0;
    idx = bit_index(int'(b), DW);
    word = int'(b) >= SLOT_BITS ? sh_r : sh_l;
    sbit = idx >= 0 && |(word & (DW'(1) << idx));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hold_full <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      sh_l <= '0;
      sh_r <= '0;
      bit_cnt <= '1;
      lrck <= 1'b0;
      sdata <= 1'b0;
      frame_tick <= 1'b0;
      underrun <= 1'b0;
    end else begin
      frame_tick <= load;
      underrun <= load && !hold_full;
      if (fall_evt) begin
        bit_cnt <= b;
        lrck <= int'(b) >= SLOT_BITS;
        sdata <= sbit;
      end
      // A load with an empty hold keeps the old shift data, so the frame repeats.
      if (load && hold_full) begin
        sh_l <= hold_l;
        sh_r <= hold_r;
        hold_full <= 1'b0;
      end else if (in_valid && !hold_full) begin
        hold_l <= pcm_l;
        hold_r <= pcm_r;
        hold_full <= 1'b1;
      end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx with a frame-level reference model
module tb_i2s_tx;
  localparam int MH = 1;
  localparam int DW = 16;
  localparam int FR = 512 * MH;
  logic clk = 0, reset = 0, in_valid = 0;
  logic [DW-1:0] pcm_l = '0, pcm_r = '0;
  logic in_ready, mclk, sclk, lrck, sdata, frame_tick, underrun;
  int checks = 0, failures = 0;
  int edges = 0, last_edges = 0, pos = -1;
  bit hfull = 0, pacc = 0, sclk_prev = 0, tick;
  logic [DW-1:0] hl, hr, pl, pr, el, er, cl = '0, cr = '0;
  logic [DW-1:0] ql[$], qr[$];
  logic [63:0] got_d, got_lr;

  i2s_tx #(.MCLK_HALF(MH), .DW(DW)) dut (
    .clk(clk), .reset(reset), .pcm_l(pcm_l), .pcm_r(pcm_r), .in_valid(in_valid),
    .in_ready(in_ready), .mclk(mclk), .sclk(sclk), .lrck(lrck), .sdata(sdata),
    .frame_tick(frame_tick), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) edges <= 0;
    else edges <= edges + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at edge %0d", name, act, req, edges);
    end
  endtask

  // Reference model: samples are frame-level objects; a frame start takes the held
  // sample if one was accepted strictly before that edge, else repeats the last one.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outs", {mclk, sclk, lrck, sdata, frame_tick, underrun, in_ready}, 7'b0000001);
      hfull = 0; cl = '0; cr = '0; pacc = 0; pos = -1; sclk_prev = 0; last_edges = 0;
      ql.delete(); qr.delete();
    end else begin
      if (edges != last_edges) begin
        last_edges = edges;
        tick = (edges % FR) == 8 * MH;
        chk("frame_tick", frame_tick, tick);
        chk("clocks", {mclk, sclk}, {(edges % (2 * MH)) >= MH, (edges % (8 * MH)) >= 4 * MH});
        chk("underrun", underrun, tick && !hfull);
        if (tick) begin
          if (hfull) begin cl = hl; cr = hr; hfull = 0; end
          ql.push_back(cl); qr.push_back(cr); pos = 0;
        end
        if (pacc) begin hl = pl; hr = pr; hfull = 1; end
        chk("in_ready", in_ready, !hfull);
        if (sclk && !sclk_prev && pos >= 0 && pos < 64) begin
          got_d[63-pos] = sdata; got_lr[63-pos] = lrck; pos++;
          if (pos == 64) begin
            chk("frame_queue", ql.size(), 1);
            if (ql.size() > 0) begin
              el = ql.pop_front(); er = qr.pop_front();
              chk("frame_lrck", got_lr, {32'h0, 32'hffff_ffff});
              chk("frame_data", got_d, {1'b0, el, 15'h0, 1'b0, er, 15'h0});
            end
          end
        end
        sclk_prev = sclk;
      end
      pacc = in_valid && !hfull; pl = pcm_l; pr = pcm_r;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit ok = 0;
    pcm_l = l; pcm_r = r; in_valid = 1;
    for (int i = 0; i < 4 * FR && !ok; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #2;
    end
    in_valid = 0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic align(input int ph);
    do begin @(posedge clk); #2; end while (edges % FR != ph);
  endtask

  initial begin
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    send(16'hA5C3, 16'h8001);
    idle(FR + 16);
    send(16'h1111, 16'h2222);
    send(16'h3333, 16'h4444);
    for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom));
    idle(2 * FR);
    send(16'h1234, 16'h5678);
    idle(3 * FR);
    align(7);
    send(16'hBEEF, 16'h0F0F);
    idle(2 * FR);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 700));
      send(16'($urandom), 16'($urandom));
    end
    idle(2 * FR);
    send(16'h7FFF, 16'h8000);
    align(8 + 40 * 8);
    #1 reset = 1;
    #1 chk("async_reset", {mclk, sclk, lrck, sdata, frame_tick, underrun, in_ready}, 7'b0000001);
    repeat (3) @(posedge clk);
    #2 reset = 0;
    idle(3 * FR);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
